d_drain_counter: RTL
====================

Name: d_drain_counter

Overview:
- Sits directly downstream of the full-logic transmit stage. Drains the two destination FIFOs (D0, D1) by issuing D0_pop/D1_pop under round-robin arbitration.
- Merges the popped words into one registered output stream and keeps a per-destination word counter.
- Once the upstream logic reports idle and both FIFOs are drained, the counters can be read back through a req/idx handshake for end-to-end checking.

Parameters:
data_width, 6, width of each FIFO word and of data_out
count_width, 5, width of each per-destination counter and of count_out

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low; 0 = reset asserted
enable  input  1  1 = draining allowed; 0 = no new pops issued
idle_in  input  1  idle indication from the full-logic state machine
empty_D0  input  1  D0 FIFO empty flag
empty_D1  input  1  D1 FIFO empty flag
data_D0  input  data_width  D0 FIFO read data, valid the cycle after D0_pop
data_D1  input  data_width  D1 FIFO read data, valid the cycle after D1_pop
D0_pop  output  1  pop strobe to D0 FIFO
D1_pop  output  1  pop strobe to D1 FIFO
data_out  output  data_width  merged output word
valid_out  output  1  data_out holds a new word this cycle
dest_out  output  1  source of data_out: 0 = D0, 1 = D1
req  input  1  counter read request
idx  input  1  counter select: 0 = D0, 1 = D1
count_out  output  count_width  selected counter value
count_valid  output  1  count_out valid this cycle

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0: D0_pop, D1_pop, data_out, valid_out, dest_out, count_out, count_valid.
  - Both counters = 0; round-robin pointer = D0 (D0 wins the first tie); state = IDLE; in-flight flags cleared.
  - Reset asserted mid-transfer drops any in-flight word; no valid_out follows.
- Pop decision (registered, evaluated every cycle in DRAIN):
  - Only one pop per cycle. Eligible source x means empty_Dx=0.
  - Both eligible: grant the source the pointer favours, then point the pointer at the other source.
  - One eligible: grant it; the pointer moves to the other source.
  - None eligible, or enable=0: no pop.
  - Empty flags are sampled in the same cycle the pop is issued. The FIFO's empty flag already reflects pops from earlier edges, so back-to-back pops are legal.
- Latency:
  - Pop asserted in cycle n; FIFO data valid in cycle n+1.
  - In cycle n+2: data_out, dest_out and valid_out=1 are registered, and the counter of that source increments.
  - Fixed 2-cycle pop-to-valid_out latency. One in-flight tag per pipeline stage, so full throughput is 1 word/cycle.
- Counters: increment by 1 per word delivered.
  - Wrap from 2^count_width-1 to 0 (unless COUNT_SAT_EN is defined).
- State machine:
  - IDLE: no pops. Go to DRAIN when enable=1.
  - DRAIN: pop per the rules above. Go to REPORT when idle_in=1, empty_D0=empty_D1=1, no pop in flight and valid_out=0. Go to IDLE when enable=0 (in-flight words still complete).
  - REPORT: no pops. A req=1 sampled at posedge gives count_out = counter[idx] and count_valid=1 on the next cycle; count_valid is 0 otherwise. Go to DRAIN if either empty flag deasserts and enable=1, or to IDLE if enable=0.
- req outside REPORT is ignored; count_out holds its last value and count_valid=0.
- A req in the same cycle as the final counter increment cannot occur, because REPORT requires the pipeline to be empty.

Optional Feature:
- Macro COUNT_SAT_EN.
- Defined: counters saturate at 2^count_width-1 and stay there until reset.
- Undefined: counters wrap to 0.

Decomposition:
- Shared package pcie_tx_pkg holds:
  - localparams for state encoding: ST_IDLE, ST_DRAIN, ST_REPORT
  - DEST_D0=0, DEST_D1=1
  - default widths DATA_W=6, CNT_W=5
- One natural sub-module, rr_arb2: 2-input round-robin arbiter with registered pointer. Takes req[1:0], outputs a one-hot grant. Instantiated once for the pop decision.

Test Plan:
- Reset, then enable=1 with D0 holding 3 words (6'b000101, 6'b010110, 6'b001110) and D1 empty -> D0_pop on 3 consecutive cycles; valid_out 2 cycles after each pop, dest_out=0, same word order; count[0]=3, count[1]=0.
- Both FIFOs non-empty with 4 words each -> pops alternate D0, D1, D0, D1… starting with D0; valid_out continuous for 8 cycles; final counts 4/4.
- enable dropped while 2 pops are in flight -> no further pops; both in-flight words still emerge with valid_out; state = IDLE.
- After draining, idle_in=1, then req=1 with idx=1 -> in REPORT, count_out=4 and count_valid=1 exactly one cycle later; req during DRAIN -> count_valid stays 0.
- Drive 33 D0 words with count_width=5 -> count[0]=1 without COUNT_SAT_EN, 31 with COUNT_SAT_EN.
- Assert reset=0 asynchronously mid-stream between clock edges -> all outputs 0 immediately; counters 0; no valid_out after release until new pops.

Source files
------------

// File: rtl/pcie_tx_pkg.sv
// ---------------------------------------------------------------------------
// pcie_tx_pkg
// Shared constants for the transmit-side drain logic:
//   ST_IDLE / ST_DRAIN / ST_REPORT : drain FSM state encoding
//   DEST_D0 / DEST_D1              : destination tags carried with each word
//   DATA_W / CNT_W                 : default FIFO-word and counter widths
// ---------------------------------------------------------------------------
package pcie_tx_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  localparam logic DEST_D0 = 1'b0;
  localparam logic DEST_D1 = 1'b1;

  localparam int DATA_W = 6;
  localparam int CNT_W  = 5;

endpackage : pcie_tx_pkg

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter with a registered priority pointer.
// The grant is combinational from req_i and the pointer; the pointer moves
// to the non-granted input whenever any grant is issued.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset (pointer -> input 0)
//   req_i  : request vector, bit k = input k wants service
//   gnt_o  : one-hot grant (all zero when nothing requests)
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // ptr_q = 0 : input 0 wins a tie; ptr_q = 1 : input 1 wins a tie.
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    // The winner loses priority, even when it was the only requester.
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arb2

// File: rtl/d_drain_counter.sv
// ---------------------------------------------------------------------------
// d_drain_counter
// Drains the D0/D1 destination FIFOs under round-robin arbitration, merges
// the popped words into one registered stream and counts words delivered
// per destination. When upstream is idle and the pipeline is empty the
// counters can be read back through a req/idx handshake.
//
// Pop-to-valid_out latency is fixed at 2 cycles: pop in cycle n, FIFO data
// in cycle n+1, data_out/valid_out (and the counter bump) in cycle n+2.
//
// Build option: define COUNT_SAT_EN to make the counters saturate at
// all-ones instead of wrapping to zero.
//
// Ports:
//   clk, reset            : clock; asynchronous active-low reset
//   enable                : allow new pops
//   idle_in               : upstream full-logic FSM is idle
//   empty_D0/empty_D1     : FIFO empty flags (current cycle)
//   data_D0/data_D1       : FIFO read data, valid the cycle after a pop
//   D0_pop/D1_pop         : pop strobes (at most one per cycle)
//   data_out/valid_out    : merged output word and its strobe
//   dest_out              : source of data_out (0 = D0, 1 = D1)
//   req/idx               : counter read request and counter select
//   count_out/count_valid : selected counter value and its strobe
// ---------------------------------------------------------------------------
module d_drain_counter
  import pcie_tx_pkg::*;
#(
  parameter int data_width  = DATA_W,
  parameter int count_width = CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   idle_in,
  input  logic                   empty_D0,
  input  logic                   empty_D1,
  input  logic [data_width-1:0]  data_D0,
  input  logic [data_width-1:0]  data_D1,
  output logic                   D0_pop,
  output logic                   D1_pop,
  output logic [data_width-1:0]  data_out,
  output logic                   valid_out,
  output logic                   dest_out,
  input  logic                   req,
  input  logic                   idx,
  output logic [count_width-1:0] count_out,
  output logic                   count_valid
);

  logic [1:0]             state_q, state_d;
  logic                   s1_valid_q;   // a pop was issued last cycle
  logic                   s1_dest_q;    // ...and this is where it came from
  logic [data_width-1:0]  data_out_q;
  logic                   valid_out_q;
  logic                   dest_out_q;
  logic [count_width-1:0] cnt0_q, cnt0_d;
  logic [count_width-1:0] cnt1_q, cnt1_d;
  logic [count_width-1:0] count_out_q;
  logic                   count_valid_q;

  logic [1:0]             arb_req;
  logic [1:0]             arb_gnt;
  logic                   pipe_busy;

  function automatic logic [count_width-1:0] bump(input logic [count_width-1:0] c);
`ifdef COUNT_SAT_EN
    return (&c) ? c : c + count_width'(1);
`else
    return c + count_width'(1);
`endif
  endfunction

  // Requests are masked outside DRAIN or when enable is low, so the
  // arbiter pointer only advances on pops that actually happen.
  assign arb_req = {~empty_D1, ~empty_D0} & {2{(state_q == ST_DRAIN) && enable}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (reset),
    .req_i (arb_req),
    .gnt_o (arb_gnt)
  );

  assign D0_pop = arb_gnt[0];
  assign D1_pop = arb_gnt[1];

  assign pipe_busy = s1_valid_q | valid_out_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (idle_in && empty_D0 && empty_D1 && !pipe_busy) begin
          state_d = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!empty_D0 || !empty_D1) begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    // The counter bumps on the same edge that registers the word onto data_out.
    if (s1_valid_q) begin
      if (s1_dest_q == DEST_D1) cnt1_d = bump(cnt1_q);
      else                      cnt0_d = bump(cnt0_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      s1_valid_q    <= 1'b0;
      s1_dest_q     <= DEST_D0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      dest_out_q    <= DEST_D0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= |arb_gnt;
      s1_dest_q   <= arb_gnt[1];
      valid_out_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_out_q <= (s1_dest_q == DEST_D0) ? data_D0 : data_D1;
        dest_out_q <= s1_dest_q;
      end
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      // Reads are honoured only in REPORT; count_out otherwise holds.
      count_valid_q <= (state_q == ST_REPORT) && req;
      if ((state_q == ST_REPORT) && req) begin
        count_out_q <= idx ? cnt1_q : cnt0_q;
      end
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign dest_out    = dest_out_q;
  assign count_out   = count_out_q;
  assign count_valid = count_valid_q;

endmodule : d_drain_counter
